// File: rtl/frame_pixel_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | frame_pixel_streamer                                                     |
// | Raster-order frame reader: addresses a sync-read memory, emits RGB666    |
// | pixels with a per-line sync pulse and a fixed inter-line blanking gap.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module frame_pixel_streamer #(
  parameter int H_SIZE = 607,
  parameter int V_SIZE = 455,
  parameter int H_GAP  = 4,
  parameter int ADDR_W = 19
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  output logic              mem_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [17:0]       mem_rdata_i,
  output logic [17:0]       raw_rgb_o,
  output logic              pixel_valid_o,
  output logic              synch_pulse_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int X_W = (H_SIZE > 1) ? $clog2(H_SIZE) : 1;
  localparam int Y_W = $clog2(V_SIZE + 1);
  localparam int G_W = $clog2(H_GAP + 1);
  localparam logic [X_W-1:0] X_LAST = X_W'(H_SIZE - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_SIZE - 1);
  localparam logic [G_W-1:0] G_LAST = G_W'(H_GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_GAP    = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t            state_q;
  logic [X_W-1:0]    x_q;
  logic [Y_W-1:0]    y_q;
  logic [G_W-1:0]    gap_q;
  logic              drain_q;
  logic              mem_en_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic              busy_q;
  logic              frame_done_q;
  logic              en_d1_q;
  logic              sync_d1_q;
  logic [17:0]       raw_q;
  logic              pv_q;
  logic              sync_q;

  // The address register itself is the frame-linear counter; it only ever steps by one.
  assign addr_d = mem_addr_q + ADDR_W'(1);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      gap_q        <= '0;
      drain_q      <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q    <= S_ACTIVE;
            mem_en_q   <= 1'b1;
            mem_addr_q <= '0;
            x_q        <= '0;
            y_q        <= '0;
            busy_q     <= 1'b1;
          end
        end
        S_ACTIVE: begin
          if (x_q == X_LAST) begin
            mem_en_q <= 1'b0;
            x_q      <= '0;
            if (y_q == Y_LAST) begin
              state_q <= S_DRAIN;
              drain_q <= 1'b0;
            end else begin
              state_q <= S_GAP;
              gap_q   <= '0;
              y_q     <= y_q + Y_W'(1);
            end
          end else begin
            x_q        <= x_q + X_W'(1);
            mem_addr_q <= addr_d;
          end
        end
        S_GAP: begin
          if (gap_q == G_LAST) begin
            state_q    <= S_ACTIVE;
            mem_en_q   <= 1'b1;
            mem_addr_q <= addr_d;
          end else begin
            gap_q <= gap_q + G_W'(1);
          end
        end
        S_DRAIN: begin
          // Two cycles let the last address ripple through memory and raw_rgb.
          if (drain_q) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
          end else begin
            drain_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      en_d1_q   <= 1'b0;
      sync_d1_q <= 1'b0;
      raw_q     <= '0;
      pv_q      <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      en_d1_q   <= mem_en_q;
      sync_d1_q <= mem_en_q && (x_q == '0);
      pv_q      <= en_d1_q;
      sync_q    <= sync_d1_q;
      if (en_d1_q) begin
        raw_q <= mem_rdata_i;
      end
    end
  end

  assign mem_en_o      = mem_en_q;
  assign mem_addr_o    = mem_addr_q;
  assign raw_rgb_o     = raw_q;
  assign pixel_valid_o = pv_q;
  assign synch_pulse_o = sync_q;
  assign busy_o        = busy_q;
  assign frame_done_o  = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_pixel_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_frame_pixel_streamer                                                  |
// | Self-checking bench: cycle table, scoreboard, and corner-case sequences. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_frame_pixel_streamer;

  localparam int H = 4;
  localparam int V = 3;
  localparam int G = 2;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [17:0]   mem_rdata = '0;
  logic [17:0]   raw_rgb;
  logic          pixel_valid, synch_pulse, busy, frame_done;

  logic          start2;
  logic          en2;
  logic [1:0]    addr2;
  logic [17:0]   rdata2 = '0;
  logic [17:0]   raw2;
  logic          pv2, sync2, busy2, fd2;

  logic          pattern;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  frame_pixel_streamer #(.H_SIZE(H), .V_SIZE(V), .H_GAP(G), .ADDR_W(AW)) u_dut (
    .clk_i(clk), .reset_i(reset), .start_i(start),
    .mem_en_o(mem_en), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata),
    .raw_rgb_o(raw_rgb), .pixel_valid_o(pixel_valid), .synch_pulse_o(synch_pulse),
    .busy_o(busy), .frame_done_o(frame_done)
  );

  frame_pixel_streamer #(.H_SIZE(2), .V_SIZE(1), .H_GAP(1), .ADDR_W(2)) u_dut2 (
    .clk_i(clk), .reset_i(reset), .start_i(start2),
    .mem_en_o(en2), .mem_addr_o(addr2), .mem_rdata_i(rdata2),
    .raw_rgb_o(raw2), .pixel_valid_o(pv2), .synch_pulse_o(sync2),
    .busy_o(busy2), .frame_done_o(fd2)
  );

  function automatic logic [17:0] model(input int a);
    if (pattern) return ((a % H) == 0) ? 18'h3F000 : 18'h00FC0;
    return 18'(a);
  endfunction

  always @(posedge clk) if (mem_en) mem_rdata <= model(int'(mem_addr));
  always @(posedge clk) if (en2) rdata2 <= 18'(addr2);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [17:0] d;
    logic        s;
  } exp_t;
  exp_t sbq[$];

  always @(posedge reset) sbq.delete();

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (pixel_valid) begin
        if (sbq.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("sb_rgb", raw_rgb, e.d);
          chk("sb_sync", synch_pulse, e.s);
        end
      end
      if (mem_en) sbq.push_back('{model(int'(mem_addr)), (int'(mem_addr) % H) == 0});
    end
  end

  typedef struct {
    int   cyc;
    logic en;
    int   addr;
    logic pv;
    logic sy;
    int   raw;
    logic busy;
    logic fd;
  } vec_t;
  vec_t tbl[20];

  function automatic vec_t mk(input int c, input logic en, input int a, input logic pv,
                              input logic sy, input int raw, input logic b, input logic fd);
    vec_t v;
    v.cyc = c; v.en = en; v.addr = a; v.pv = pv; v.sy = sy; v.raw = raw; v.busy = b; v.fd = fd;
    return v;
  endfunction

  task automatic kick();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_en"}, mem_en, 0);
    chk({p, "_addr"}, mem_addr, 0);
    chk({p, "_rgb"}, raw_rgb, 0);
    chk({p, "_pv"}, pixel_valid, 0);
    chk({p, "_sync"}, synch_pulse, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_fd"}, frame_done, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   bad;
    int   nsync;
    bit   done;
    logic exp_sy;
    logic e2_en[5]   = '{1, 1, 0, 0, 0};
    int   e2_addr[5] = '{0, 1, 1, 1, 1};
    logic e2_pv[5]   = '{0, 0, 1, 1, 0};
    logic e2_sy[5]   = '{0, 0, 1, 0, 0};
    logic e2_busy[5] = '{1, 1, 1, 1, 0};
    logic e2_fd[5]   = '{0, 0, 0, 0, 1};

    tbl[0]  = mk(1,  1, 0,  0, 0, 0,  1, 0);
    tbl[1]  = mk(2,  1, 1,  0, 0, 0,  1, 0);
    tbl[2]  = mk(3,  1, 2,  1, 1, 0,  1, 0);
    tbl[3]  = mk(4,  1, 3,  1, 0, 1,  1, 0);
    tbl[4]  = mk(5,  0, 3,  1, 0, 2,  1, 0);
    tbl[5]  = mk(6,  0, 3,  1, 0, 3,  1, 0);
    tbl[6]  = mk(7,  1, 4,  0, 0, 3,  1, 0);
    tbl[7]  = mk(8,  1, 5,  0, 0, 3,  1, 0);
    tbl[8]  = mk(9,  1, 6,  1, 1, 4,  1, 0);
    tbl[9]  = mk(10, 1, 7,  1, 0, 5,  1, 0);
    tbl[10] = mk(11, 0, 7,  1, 0, 6,  1, 0);
    tbl[11] = mk(12, 0, 7,  1, 0, 7,  1, 0);
    tbl[12] = mk(13, 1, 8,  0, 0, 7,  1, 0);
    tbl[13] = mk(14, 1, 9,  0, 0, 7,  1, 0);
    tbl[14] = mk(15, 1, 10, 1, 1, 8,  1, 0);
    tbl[15] = mk(16, 1, 11, 1, 0, 9,  1, 0);
    tbl[16] = mk(17, 0, 11, 1, 0, 10, 1, 0);
    tbl[17] = mk(18, 0, 11, 1, 0, 11, 1, 0);
    tbl[18] = mk(19, 0, 11, 0, 0, 11, 0, 1);
    tbl[19] = mk(20, 0, 11, 0, 0, 11, 0, 0);

    reset = 1'b1; start = 1'b0; start2 = 1'b0; pattern = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk) reset = 1'b0;

    // Frame 1: cycle-exact table, cycle n sampled at the n-th negedge after the start edge.
    kick();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("c%0d_en", tbl[i].cyc), mem_en, tbl[i].en);
      chk($sformatf("c%0d_addr", tbl[i].cyc), mem_addr, tbl[i].addr);
      chk($sformatf("c%0d_pv", tbl[i].cyc), pixel_valid, tbl[i].pv);
      chk($sformatf("c%0d_sync", tbl[i].cyc), synch_pulse, tbl[i].sy);
      chk($sformatf("c%0d_rgb", tbl[i].cyc), raw_rgb, tbl[i].raw);
      chk($sformatf("c%0d_busy", tbl[i].cyc), busy, tbl[i].busy);
      chk($sformatf("c%0d_fd", tbl[i].cyc), frame_done, tbl[i].fd);
    end

    // Start held high: ignored while busy, accepted in the frame_done cycle.
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      exp_sy = (c == 3 || c == 9 || c == 15 || c == 22 || c == 28 || c == 34);
      chk($sformatf("b2b_c%0d_sync", c), synch_pulse, exp_sy);
      if (c == 7) chk("b2b_c7_addr", mem_addr, 4);
      if (c == 19) begin
        chk("b2b_c19_fd", frame_done, 1);
        chk("b2b_c19_en", mem_en, 0);
      end
      if (c == 20) begin
        chk("b2b_c20_en", mem_en, 1);
        chk("b2b_c20_addr", mem_addr, 0);
        chk("b2b_c20_busy", busy, 1);
      end
    end
    start = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (!busy && !pixel_valid && !mem_en) done = 1'b1;
    end
    chk("b2b_idle_timeout", done, 1);

    // Reset asserted in cycle 8 (mid line 1).
    kick();
    repeat (7) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1 chk_zero("midrst");
    @(negedge clk) reset = 1'b0;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (mem_en || pixel_valid || frame_done || busy) bad++;
    end
    chk("midrst_quiet", bad, 0);
    kick();
    @(negedge clk);
    chk("restart_en", mem_en, 1);
    chk("restart_addr", mem_addr, 0);
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (frame_done) done = 1'b1;
    end
    chk("restart_fd_timeout", done, 1);

    // Colour pattern: red exactly on the sync pixel.
    @(negedge clk) pattern = 1'b1;
    kick();
    nsync = 0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (pixel_valid) begin
        chk("pat_red_on_sync", raw_rgb == 18'h3F000, synch_pulse);
        if (synch_pulse) nsync++;
      end
      if (frame_done) done = 1'b1;
    end
    chk("pat_fd_timeout", done, 1);
    chk("pat_sync_count", nsync, V);
    @(negedge clk) pattern = 1'b0;

    // Minimal geometry 2x1, gap 1: no blanking state, frame_done in cycle 5.
    @(negedge clk) start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("small_c%0d_en", c + 1), en2, e2_en[c]);
      chk($sformatf("small_c%0d_addr", c + 1), addr2, e2_addr[c]);
      chk($sformatf("small_c%0d_pv", c + 1), pv2, e2_pv[c]);
      chk($sformatf("small_c%0d_sync", c + 1), sync2, e2_sy[c]);
      chk($sformatf("small_c%0d_busy", c + 1), busy2, e2_busy[c]);
      chk($sformatf("small_c%0d_fd", c + 1), fd2, e2_fd[c]);
      if (c == 2) chk("small_c3_rgb", raw2, 0);
      if (c == 3) chk("small_c4_rgb", raw2, 1);
    end

    repeat (3) @(negedge clk);
    chk("sb_leftover", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
